// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifts,
// result and SZCV flags held in registers until the consumer accepts them.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       SZCV,
  output logic             wb
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]   EXT_ONE   = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] work_r, out_r;
  logic [SHW-1:0]   cnt_r;
  logic [3:0]       op_r, szcv_r;
  logic             wb_r;

  logic [WIDTH:0]   ae_s, be_s, sum_s, diff_s;
  logic [WIDTH-1:0] nb_s, res_s, step_s;
  logic             c_s, v_s, wb_s, known_s, is_shift_s, start_shift_s, bit_out_s;
  logic [SHW-1:0]   amt_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out       = out_r;
  assign SZCV      = szcv_r;
  assign wb        = wb_r;

  assign amt_s         = inB[SHW-1:0];
  assign is_shift_s    = (op[3:2] == 2'b10);
  assign start_shift_s = is_shift_s && (amt_s != CNT_ZERO);

  // Single-cycle result and flags for the operation presented at the input
  always_comb begin
    ae_s    = {inA[WIDTH-1], inA};
    be_s    = {inB[WIDTH-1], inB};
    sum_s   = ae_s + be_s;
    diff_s  = ae_s + (~be_s + EXT_ONE);
    nb_s    = ~inB + {{(WIDTH-1){1'b0}}, 1'b1};
    res_s   = DATA_ZERO;
    c_s     = 1'b0;
    v_s     = 1'b0;
    wb_s    = 1'b1;
    known_s = 1'b1;
    case (op)
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (inA[WIDTH-1] == inB[WIDTH-1]) && (res_s[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_s = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        v_s   = (inA[WIDTH-1] == nb_s[WIDTH-1]) && (res_s[WIDTH-1] != inA[WIDTH-1]);
        wb_s  = (op == OP_SUB);
      end
      OP_AND: res_s = inA & inB;
      OP_OR:  res_s = inA | inB;
      OP_XOR: res_s = inA ^ inB;
      OP_MOV: res_s = inB;
      // Zero-distance shifts bypass the SHIFT state and pass A through
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: res_s = inA;
      default: begin
        wb_s    = 1'b0;
        known_s = 1'b0;
      end
    endcase
  end

  // One-bit shift step of the work register and the bit it pushes out
  always_comb begin
    step_s    = work_r;
    bit_out_s = 1'b0;
    case (op_r)
      OP_SLL: begin
        step_s    = {work_r[WIDTH-2:0], 1'b0};
        bit_out_s = work_r[WIDTH-1];
      end
      OP_SLR: step_s = {work_r[WIDTH-2:0], work_r[WIDTH-1]};
      OP_SRL: begin
        step_s    = {1'b0, work_r[WIDTH-1:1]};
        bit_out_s = work_r[0];
      end
      OP_SRA: begin
        step_s    = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
        bit_out_s = work_r[0];
      end
      default: begin
        step_s    = work_r;
        bit_out_s = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = start_shift_s ? SHIFT : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: operand capture, shift iteration, result and flag hold
  always_ff @(posedge clk) begin
    if (rst) begin
      work_r <= DATA_ZERO;
      cnt_r  <= CNT_ZERO;
      op_r   <= 4'b0000;
      out_r  <= DATA_ZERO;
      szcv_r <= 4'b0000;
      wb_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r <= op;
            if (start_shift_s) begin
              work_r <= inA;
              cnt_r  <= amt_s;
            end else begin
              out_r  <= res_s;
              szcv_r <= known_s ? {res_s[WIDTH-1], (res_s == DATA_ZERO), c_s, v_s} : 4'b0000;
              wb_r   <= wb_s;
            end
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            out_r  <= step_s;
            szcv_r <= {step_s[WIDTH-1], (step_s == DATA_ZERO), bit_out_s, 1'b0};
            wb_r   <= 1'b1;
          end
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: hand-computed results, flags, latency,
// reset abort, backpressure and back-to-back throughput.
module tb_alu_mc;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, wb;
  logic [15:0] inA, inB, out;
  logic [3:0]  op, SZCV;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .SZCV(SZCV), .wb(wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure cycles to out_valid, check result, then take it
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_out,
                        input logic [3:0] exp_szcv, input logic exp_wb, input int exp_lat);
    int lat;
    check({tag, "/rdy"}, {31'd0, in_ready}, 32'd1);
    op = o; inA = a; inB = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 4'($urandom); inA = 16'($urandom); inB = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "/lat"}, lat, exp_lat);
    check({tag, "/out"}, {16'd0, out}, {16'd0, exp_out});
    check({tag, "/szcv"}, {28'd0, SZCV}, {28'd0, exp_szcv});
    check({tag, "/wb"}, {31'd0, wb}, {31'd0, exp_wb});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inA = 16'h0000; inB = 16'h0000; op = OP_ADD;
    tick(); tick();
    rst = 1'b0;
    check("rst/ready", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst/out", {16'd0, out}, 32'd0);
    check("rst/szcv_wb", {27'd0, SZCV, wb}, 32'd0);

    // Abort a long shift with reset
    op = OP_SRL; inA = 16'h1234; inB = 16'h000A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort/busy", {30'd0, in_ready, out_valid}, 32'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("abort/ready", {30'd0, in_ready, out_valid}, 32'd2);
    check("abort/out", {16'd0, out}, 32'd0);
    check("abort/szcv", {28'd0, SZCV}, 32'd0);

    run_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1, 1);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0100, 1'b1, 1);
    run_op("sub_eq",   OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b1, 1);
    run_op("cmp_eq",   OP_CMP, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b0, 1);
    run_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b1, 1);
    run_op("and",      OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1'b1, 1);
    run_op("or_zero",  OP_OR,  16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b1, 1);
    run_op("mov",      OP_MOV, 16'hFFFF, 16'h00A5, 16'h00A5, 4'b0000, 1'b1, 1);
    run_op("sll1",     OP_SLL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b1, 2);
    run_op("slr4",     OP_SLR, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 1'b1, 5);
    run_op("sra15",    OP_SRA, 16'h8001, 16'h000F, 16'hFFFF, 4'b1000, 1'b1, 16);
    run_op("srl0",     OP_SRL, 16'h8001, 16'h0000, 16'h8001, 4'b1000, 1'b1, 1);
    run_op("srl3",     OP_SRL, 16'h000C, 16'h0003, 16'h0001, 4'b0010, 1'b1, 4);
    run_op("sra1_msk", OP_SRA, 16'h8001, 16'h0031, 16'hC000, 4'b1010, 1'b1, 2);
    run_op("rsv1110",  4'b1110, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b0, 1);
    run_op("rsv0111",  4'b0111, 16'hFFFF, 16'h0001, 16'h0000, 4'b0000, 1'b0, 1);

    // Backpressure: result held, new request ignored while stalled
    op = OP_XOR; inA = 16'hFF00; inB = 16'h0FF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp/valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp/out", {16'd0, out}, 32'h0000F0F0);
      check("bp/szcv", {28'd0, SZCV}, 32'h8);
      check("bp/rdy", {31'd0, in_ready}, 32'd0);
      if (k == 2) begin
        op = OP_ADD; inA = 16'h0001; inB = 16'h0001; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp/taken", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    check("bp/ignored", {30'd0, out_valid, in_ready}, 32'd1);

    // Back-to-back with consumer always ready: one accept every 2 cycles
    op = OP_ADD; inA = 16'h0003; inB = 16'h0004; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("b2b/accepts", acc, 32'd10);
    check("b2b/out", {16'd0, out}, 32'h7);
    tick();
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
